// File: rtl/usb_gpx_pkg.sv
// Shared constants for the MAX3421E GPX event controller.
// Register addresses, edge bit indices and the filter state type.
package usb_gpx_pkg;

    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_EVCNT = 2'd3;

    localparam int RISE_BIT = 0;
    localparam int FALL_BIT = 1;

    typedef enum logic {
        STABLE,
        QUALIFY
    } filt_state_e;

endpackage

// File: rtl/usb_gpx_event_ctrl_if.sv
// Avalon-MM slave bus bundle for the GPX event controller.
// The CPU side drives the master modport, the controller takes the slave one.
interface usb_gpx_event_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/usb_gpx_filter.sv
// GPX pin synchronizer plus qualifying glitch filter producing a clean level.
// The filter exists only with USB_GPX_FILTER_EN; otherwise level is the synced pin.
module usb_gpx_filter #(
    parameter int unsigned FILTER_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic level_o
);

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_cycles
        $error("FILTER_CYCLES must be within 1..255");
    end

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= in_i;
            s2_q <= s1_q;
        end
    end

`ifdef USB_GPX_FILTER_EN
    import usb_gpx_pkg::*;

    localparam logic [7:0] LAST = 8'(FILTER_CYCLES - 1);

    filt_state_e state_q;
    logic [7:0]  cnt_q;
    logic        level_q;
    logic        diff;

    assign diff    = s2_q ^ level_q;
    assign level_o = level_q;

    // Level flips on the FILTER_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            unique case (state_q)
                STABLE: begin
                    if (diff) begin
                        if (cnt_q == LAST) begin
                            level_q <= ~level_q;
                        end else begin
                            cnt_q   <= cnt_q + 8'd1;
                            state_q <= QUALIFY;
                        end
                    end
                end
                QUALIFY: begin
                    if (!diff || cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= STABLE;
                        if (diff) level_q <= ~level_q;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end
`else
    assign level_o = s2_q;
`endif

endmodule

// File: rtl/usb_gpx_event_ctrl.sv
// Avalon-MM GPX event controller: edge capture, irq mask and saturating event count.
// Glitch filtering is enabled by defining USB_GPX_FILTER_EN.
module usb_gpx_event_ctrl
    import usb_gpx_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    usb_gpx_event_ctrl_if.slave  bus,
    input  logic                 in_port,
    output logic                 irq
);

    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("CNT_W must be within 1..32");
    end

    logic             level;
    logic             rise;
    logic             fall;
    logic             any_edge;
    logic             wr;
    logic             level_d_q;
    logic [1:0]       mask_q;
    logic [1:0]       mask_d;
    logic [1:0]       edge_q;
    logic [1:0]       edge_d;
    logic [CNT_W-1:0] evcnt_q;
    logic [CNT_W-1:0] evcnt_d;
    logic [31:0]      rdata_d;

    usb_gpx_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk    (clk),
        .reset_n(reset_n),
        .in_i   (in_port),
        .level_o(level)
    );

    assign rise     = level & ~level_d_q;
    assign fall     = ~level & level_d_q;
    assign any_edge = rise | fall;
    assign wr       = bus.chipselect & ~bus.write_n;
    assign irq      = |(edge_q & mask_q);

    // New edges are OR-ed in after the W1C so a same-cycle set wins.
    always_comb begin
        mask_d  = mask_q;
        edge_d  = edge_q;
        evcnt_d = evcnt_q;
        rdata_d = '0;
        if (wr && bus.address == ADDR_MASK) mask_d = bus.writedata[1:0];
        if (wr && bus.address == ADDR_EDGE) edge_d = edge_q & ~bus.writedata[1:0];
        edge_d[RISE_BIT] = edge_d[RISE_BIT] | rise;
        edge_d[FALL_BIT] = edge_d[FALL_BIT] | fall;
        if (wr && bus.address == ADDR_EVCNT) begin
            evcnt_d = any_edge ? CNT_W'(1) : '0;
        end else if (any_edge && !(&evcnt_q)) begin
            evcnt_d = evcnt_q + CNT_W'(1);
        end
        unique case (bus.address)
            ADDR_LEVEL: rdata_d[0]         = level;
            ADDR_MASK:  rdata_d[1:0]       = mask_q;
            ADDR_EDGE:  rdata_d[1:0]       = edge_q;
            ADDR_EVCNT: rdata_d[CNT_W-1:0] = evcnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_d_q    <= 1'b0;
            mask_q       <= '0;
            edge_q       <= '0;
            evcnt_q      <= '0;
            bus.readdata <= '0;
        end else begin
            level_d_q    <= level;
            mask_q       <= mask_d;
            edge_q       <= edge_d;
            evcnt_q      <= evcnt_d;
            bus.readdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// Scoreboard bench for usb_gpx_event_ctrl, valid with or without USB_GPX_FILTER_EN.
// Expected readdata/irq per clock come from a pin-history reference model.
module tb_usb_gpx_event_ctrl;

    localparam int unsigned FC    = 16;
    localparam int unsigned CW    = 4;
    localparam int unsigned CMAX  = (1 << CW) - 1;
    localparam int          NRAND = 3000;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic in_port;
    logic irq;

    usb_gpx_event_ctrl_if bus ();

    usb_gpx_event_ctrl #(
        .FILTER_CYCLES(FC),
        .CNT_W        (CW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave),
        .in_port(in_port),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    bit          pin_h[$];
    bit          L1, L2;
    bit [1:0]    m_mask, m_edge;
    int unsigned m_cnt;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%h exp=%h", nm, cyc, got, exp);
    endfunction

    function automatic bit pin_at(int i);
        if (i < 0 || i >= pin_h.size()) return 1'b0;
        return pin_h[i];
    endfunction

    function automatic void model_reset();
        pin_h.delete();
        L1 = 0; L2 = 0;
        m_mask = 0; m_edge = 0; m_cnt = 0;
    endfunction

    // One clock edge of the reference: level from pin history, then registers.
    function automatic void model_step();
        int t;
        bit nl, rise, fall, ev, wr;
        logic [31:0] rd;
        pin_h.push_back(in_port);
        t = pin_h.size() - 1;
`ifdef USB_GPX_FILTER_EN
        nl = ~L1;
        for (int k = 2; k <= int'(FC) + 1; k++)
            if (pin_at(t - k) == L1) nl = L1;
`else
        nl = pin_at(t - 1);
`endif
        rise = L1 & ~L2;
        fall = ~L1 & L2;
        ev   = rise | fall;
        case (bus.address)
            2'd0: rd = {31'b0, L1};
            2'd1: rd = {30'b0, m_mask};
            2'd2: rd = {30'b0, m_edge};
            default: rd = m_cnt;
        endcase
        wr = bus.chipselect && !bus.write_n;
        if (wr && bus.address == 2'd1) m_mask = bus.writedata[1:0];
        if (wr && bus.address == 2'd2) m_edge = m_edge & ~bus.writedata[1:0];
        m_edge = m_edge | {fall, rise};
        if (wr && bus.address == 2'd3) m_cnt = ev ? 1 : 0;
        else if (ev && m_cnt < CMAX) m_cnt++;
        sb.push_back('{rd: rd, irq: |(m_edge & m_mask)});
        L2 = L1;
        L1 = nl;
        cyc++;
    endfunction

    task automatic drive(bit p, bit cs, bit wn, logic [1:0] a, logic [31:0] d);
        @(negedge clk);
        #1;
        in_port        = p;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = d;
        @(posedge clk);
        model_step();
    endtask

    task automatic rd_op(bit p, logic [1:0] a);
        drive(p, 1'b1, 1'b1, a, $urandom());
    endtask

    task automatic wr_op(bit p, logic [1:0] a, logic [31:0] d);
        drive(p, 1'b1, 1'b0, a, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n        = 1'b0;
        in_port        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        #1;
        chk("reset_readdata", bus.readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        model_step();
    endtask

    task automatic rand_op(bit p);
        int r;
        bit cs, wn;
        logic [1:0] a;
        logic [31:0] d;
        r  = $urandom_range(0, 99);
        d  = $urandom();
        a  = 2'($urandom_range(0, 3));
        cs = 1'b1;
        wn = 1'b1;
        if (r < 15) begin
            cs = 1'b0;
            wn = 1'($urandom_range(0, 1));
        end else if (r >= 80) begin
            wn = 1'b0;
            a  = (r < 88) ? 2'd1 : (r < 95) ? 2'd2 : 2'd3;
        end
        if (L1 != L2 && $urandom_range(0, 3) == 0) begin
            cs = 1'b1;
            wn = 1'b0;
            a  = 2'($urandom_range(2, 3));
            d  = 32'h3;
        end
        drive(p, cs, wn, a, d);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("readdata", bus.readdata, e.rd);
                chk("irq", {31'b0, irq}, {31'b0, e.irq});
            end
        end
    end

    initial begin : stim
        bit pv;
        int hold;
        reset_n        = 1'b0;
        in_port        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        model_reset();
        do_reset();
        for (int a = 0; a < 4; a++) rd_op(1'b0, 2'(a));
        wr_op(1'b0, 2'd1, 32'hFFFF_FFFF);
        for (int k = 0; k < 20; k++) rd_op(1'b1, 2'(k % 4));
        for (int k = 0; k < 30; k++) rd_op(1'b0, 2'(k % 4));
        wr_op(1'b0, 2'd2, 32'h3);
        wr_op(1'b0, 2'd3, 32'h0);
        for (int k = 0; k < 10; k++) rd_op(1'b1, 2'(k % 4));
        for (int k = 0; k < 30; k++) rd_op(1'b0, 2'(k % 4));
        // W1C colliding with a fresh rise, then a clean W1C.
        for (int k = 0; k < 30; k++) begin
            if (L1 != L2) wr_op(1'b1, 2'd2, 32'h1);
            else rd_op(1'b1, 2'd2);
        end
        wr_op(1'b1, 2'd2, 32'h1);
        rd_op(1'b1, 2'd2);
        // Saturate the event counter, then clear it on an edge.
        wr_op(1'b1, 2'd3, 32'h0);
        pv = 1'b1;
        for (int n = 0; n < int'(CMAX) + 3; n++) begin
            pv = ~pv;
            for (int k = 0; k < int'(FC) + 2; k++) rd_op(pv, 2'd3);
        end
        pv = ~pv;
        for (int k = 0; k < int'(FC) + 6; k++) begin
            if (L1 != L2) wr_op(pv, 2'd3, 32'hDEAD_BEEF);
            else rd_op(pv, 2'd3);
        end
        // Reset in the middle of a qualification window.
        for (int k = 0; k < 8; k++) rd_op(1'b1, 2'd0);
        do_reset();
        wr_op(1'b0, 2'd1, 32'h3);
        for (int k = 0; k < 40; k++) rd_op(1'b0, 2'(k % 4));
        pv = 1'b0;
        for (int i = 0; i < NRAND;) begin
            hold = $urandom_range(1, int'(FC) + 8);
            pv   = ~pv;
            for (int k = 0; k < hold && i < NRAND; k++) begin
                rand_op(pv);
                i++;
            end
        end
        for (int k = 0; k < 4; k++) rd_op(pv, 2'(k));
        @(negedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
